// File: rtl/ppu_vram_arbiter.sv
//-----------------------------------------------------------------------------
// ppu_vram_arbiter
//
// Owns the PPU's single VRAM port and shares it between the scanline renderer
// and the CPU PPUDATA path. The renderer gets the port for a whole scanline.
// CPU reads wait until the port is free. CPU writes are either queued in a
// small FIFO or served directly, depending on the build.
//
// Build option:
//   PPU_ARB_WRITE_FIFO_EN  defined   -> CPU writes are queued in a FIFO of
//                                       FIFO_DEPTH entries and acked on push.
//                          undefined -> no FIFO. A write is served from IDLE
//                                       and acked in the cycle mem_we is high.
//                                       fifo_level is tied to 0.
//
// Parameters:
//   FIFO_DEPTH   CPU write-queue entries (power of two, 2..16)
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   render_req    renderer wants the port (held for a whole scanline)
//   render_addr   renderer fetch address
//   render_grant  renderer owns the port
//   cpu_req       CPU access request, held until cpu_ack
//   cpu_we        1 = write, 0 = read
//   cpu_addr      CPU VRAM address
//   cpu_wdata     CPU write data
//   cpu_ack       one-cycle pulse: write accepted or read data valid
//   cpu_rdata     read data, valid with cpu_ack, held until the next read
//   mem_addr      VRAM address, bits [15:14] always 0
//   mem_wdata     VRAM write data
//   mem_we        VRAM write strobe
//   mem_rdata     VRAM read data, valid one cycle after mem_addr
//   fifo_level    number of queued CPU writes
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module ppu_vram_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        render_req,
  input  logic [15:0] render_addr,
  output logic        render_grant,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [4:0]  fifo_level
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RENDER,
    S_CPU_WR,
    S_CPU_RD_ADDR,
    S_CPU_RD_DATA
  } state_t;

  localparam logic [4:0] DEPTH_L = FIFO_DEPTH[4:0];

  state_t      r_state;
  logic        r_render_grant;
  logic        r_cpu_ack;
  logic [7:0]  r_cpu_rdata;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic        r_mem_we;

  // A request still high during its own ack cycle is the one just served,
  // not a new one, so it is masked for that cycle.
  logic w_cpu_rd;
  logic w_cpu_wr;
  assign w_cpu_rd = cpu_req & ~cpu_we & ~r_cpu_ack;
  assign w_cpu_wr = cpu_req &  cpu_we & ~r_cpu_ack;

  logic        w_idle_free;   // IDLE and the renderer is not asking
  logic        w_wr_start;    // IDLE -> CPU_WR this cycle
  logic [13:0] w_wr_addr;
  logic [7:0]  w_wr_data;
  logic        w_wr_ack;      // write ack to register this cycle
  logic        w_rd_ok;       // a read may start (no older writes pending)
  logic        w_unused;

  assign w_idle_free = (r_state == S_IDLE) && !render_req;

`ifdef PPU_ARB_WRITE_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [13:0]      r_fifo_addr [FIFO_DEPTH];
  logic [7:0]       r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [4:0]       r_level;
  logic             w_full;
  logic             w_empty;
  logic             w_push;

  assign w_full     = (r_level == DEPTH_L);
  assign w_empty    = (r_level == 5'd0);
  assign w_push     = w_cpu_wr & ~w_full;
  assign w_wr_start = w_idle_free & ~w_empty;
  assign w_wr_addr  = r_fifo_addr[r_rd_ptr];
  assign w_wr_data  = r_fifo_data[r_rd_ptr];
  assign w_wr_ack   = w_push;
  assign w_rd_ok    = w_empty;
  assign fifo_level = r_level;
  assign w_unused   = ^{render_addr[15:14], cpu_addr[15:14]};

  // NOTE: the FIFO storage has no reset; the pointers and level decide which
  // entries are valid, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= cpu_addr[13:0];
      r_fifo_data[r_wr_ptr] <= cpu_wdata;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= 5'd0;
    end else begin
      if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_wr_start) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_wr_start})
        2'b10:   r_level <= r_level + 5'd1;
        2'b01:   r_level <= r_level - 5'd1;
        default: r_level <= r_level;
      endcase
    end
  end
`else
  assign w_wr_start = w_idle_free & w_cpu_wr;
  assign w_wr_addr  = cpu_addr[13:0];
  assign w_wr_data  = cpu_wdata;
  assign w_wr_ack   = w_wr_start;
  assign w_rd_ok    = 1'b1;
  assign fifo_level = 5'd0;
  assign w_unused   = ^{render_addr[15:14], cpu_addr[15:14], DEPTH_L};
`endif

  // NOTE: state and outputs use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_render_grant <= 1'b0;
      r_cpu_ack      <= 1'b0;
      r_cpu_rdata    <= 8'h00;
      r_mem_addr     <= 16'h0000;
      r_mem_wdata    <= 8'h00;
      r_mem_we       <= 1'b0;
    end else begin
      r_mem_we  <= 1'b0;
      r_cpu_ack <= w_wr_ack;
      case (r_state)
        S_IDLE: begin
          if (render_req) begin
            r_state        <= S_RENDER;
            r_render_grant <= 1'b1;
          end else if (w_wr_start) begin
            r_state     <= S_CPU_WR;
            r_mem_addr  <= {2'b00, w_wr_addr};
            r_mem_wdata <= w_wr_data;
            r_mem_we    <= 1'b1;
          end else if (w_cpu_rd && w_rd_ok) begin
            r_state    <= S_CPU_RD_ADDR;
            r_mem_addr <= {2'b00, cpu_addr[13:0]};
          end
        end
        S_RENDER: begin
          if (!render_req) begin
            r_state        <= S_IDLE;
            r_render_grant <= 1'b0;
          end
        end
        S_CPU_WR:      r_state <= S_IDLE;
        S_CPU_RD_ADDR: r_state <= S_CPU_RD_DATA;
        S_CPU_RD_DATA: begin
          r_cpu_rdata <= mem_rdata;
          r_cpu_ack   <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // While rendering, the renderer's address goes straight to memory so its
  // fetch sequencer sees no extra pipeline stage.
  assign render_grant = r_render_grant;
  assign mem_addr     = r_render_grant ? {2'b00, render_addr[13:0]} : r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_we       = r_mem_we;
  assign cpu_ack      = r_cpu_ack;
  assign cpu_rdata    = r_cpu_rdata;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
//-----------------------------------------------------------------------------
// tb_ppu_vram_arbiter
//
// Directed bench for ppu_vram_arbiter with a small VRAM model (one-cycle read
// latency) and a log of every memory write. Inputs change 1 ns after a rising
// edge; outputs are sampled at the same point. The FIFO scenarios are built
// when PPU_ARB_WRITE_FIFO_EN is defined, the direct-write scenario otherwise.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ppu_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        render_req;
  logic [15:0] render_addr;
  logic        render_grant;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [4:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  ppu_vram_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .render_req   (render_req),
    .render_addr  (render_addr),
    .render_grant (render_grant),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  // VRAM model, write log and protocol monitors
  logic [7:0]  vram [0:16383];
  logic        pre_we = 1'b0;
  logic [13:0] pre_addr = 14'h0;
  logic [7:0]  pre_data = 8'h00;
  logic [15:0] log_addr [$];
  logic [7:0]  log_data [$];
  logic        prev_ack = 1'b0;
  int          bad_we_grant = 0;
  int          bad_addr_hi  = 0;
  int          bad_ack_run  = 0;

  always @(posedge clk) begin
    mem_rdata <= vram[mem_addr[13:0]];
    if (mem_we) vram[mem_addr[13:0]] <= mem_wdata;
    else if (pre_we) vram[pre_addr] <= pre_data;
    if (reset) begin
      if (mem_we) begin
        log_addr.push_back(mem_addr);
        log_data.push_back(mem_wdata);
      end
      if (mem_we && render_grant) bad_we_grant <= bad_we_grant + 1;
      if (mem_addr[15:14] != 2'b00) bad_addr_hi <= bad_addr_hi + 1;
      if (cpu_ack && prev_ack) bad_ack_run <= bad_ack_run + 1;
      prev_ack <= cpu_ack;
    end else begin
      prev_ack <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [13:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; render_req = 1'b0; render_addr = 16'h0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (render_grant !== 1'b0) begin n_fail++; $display("FAIL reset_render_grant: got %b, expected 0", render_grant); end
    n_checks++;
    if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ack: got %b, expected 0", cpu_ack); end
    n_checks++;
    if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b, expected 0", mem_we); end
    n_checks++;
    if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h, expected 0000", mem_addr); end
    n_checks++;
    if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem_wdata: got %h, expected 00", mem_wdata); end
    n_checks++;
    if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_cpu_rdata: got %h, expected 00", cpu_rdata); end
    n_checks++;
    if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_fifo_level: got %0d, expected 0", fifo_level); end
  endtask

  task automatic test_render();
    render_addr = 16'hE3C0;
    render_req  = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      tick();
      n_checks++;
      if (render_grant !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h23C0) begin
        n_fail++;
        $display("FAIL render_hold cycle %0d: got grant=%b we=%b addr=%h, expected grant=1 we=0 addr=23c0",
                 c, render_grant, mem_we, mem_addr);
      end
    end
    render_addr = 16'hFFFF;
    #1;
    n_checks++;
    if (mem_addr !== 16'h3FFF) begin n_fail++; $display("FAIL render_addr_track: got %h, expected 3fff", mem_addr); end
    render_req  = 1'b0;
    render_addr = 16'h0000;
    tick();
    n_checks++;
    if (render_grant !== 1'b0) begin n_fail++; $display("FAIL render_release: got %b, expected 0", render_grant); end
  endtask

  task automatic test_reset_mid_render();
    render_req = 1'b1;
    tick();
    n_checks++;
    if (render_grant !== 1'b1) begin n_fail++; $display("FAIL rst_mid_grant_before: got %b, expected 1", render_grant); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (render_grant !== 1'b0) begin n_fail++; $display("FAIL rst_mid_grant_async: got %b, expected 0", render_grant); end
    render_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if (render_grant !== 1'b0 || mem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_mid_after: got grant=%b addr=%h, expected grant=0 addr=0000", render_grant, mem_addr);
    end
  endtask

  task automatic test_cpu_read();
    preload(14'h23C0, 8'h5A);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hE3C0;
    tick();  // N
    n_checks++;
    if (mem_addr !== 16'h23C0 || cpu_ack !== 1'b0) begin
      n_fail++; $display("FAIL read_addr_phase: got addr=%h ack=%b, expected addr=23c0 ack=0", mem_addr, cpu_ack);
    end
    tick();  // N+1
    n_checks++;
    if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL read_no_early_ack: got %b, expected 0", cpu_ack); end
    tick();  // N+2
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h5A) begin
      n_fail++; $display("FAIL read_data: got ack=%b rdata=%h, expected ack=1 rdata=5a", cpu_ack, cpu_rdata);
    end
    tick();  // request still high during the ack cycle: must not restart
    n_checks++;
    if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL read_single_ack: got %b, expected 0", cpu_ack); end
    cpu_req = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (cpu_ack !== 1'b0 || cpu_rdata !== 8'h5A) begin
      n_fail++; $display("FAIL read_hold: got ack=%b rdata=%h, expected ack=0 rdata=5a", cpu_ack, cpu_rdata);
    end
  endtask

  task automatic test_read_then_render();
    preload(14'h0100, 8'h3C);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    tick();  // N: read starts
    render_req  = 1'b1;
    render_addr = 16'h2000;
    tick();  // N+1
    n_checks++;
    if (render_grant !== 1'b0) begin n_fail++; $display("FAIL rd_render_wait1: got %b, expected 0", render_grant); end
    tick();  // N+2
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h3C || render_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_render_data: got ack=%b rdata=%h grant=%b, expected ack=1 rdata=3c grant=0",
               cpu_ack, cpu_rdata, render_grant);
    end
    cpu_req = 1'b0;
    tick();  // N+3
    n_checks++;
    if (render_grant !== 1'b1 || cpu_ack !== 1'b0) begin
      n_fail++; $display("FAIL rd_render_grant: got grant=%b ack=%b, expected grant=1 ack=0", render_grant, cpu_ack);
    end
    render_req = 1'b0;
    tick();
    n_checks++;
    if (render_grant !== 1'b0) begin n_fail++; $display("FAIL rd_render_release: got %b, expected 0", render_grant); end
  endtask

`ifdef PPU_ARB_WRITE_FIFO_EN
  task automatic test_fifo_render();
    int base;
    int k;
    bit got;
    base = log_addr.size();
    render_req = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b1;
      cpu_addr = 16'h2000 + 16'(i); cpu_wdata = 8'hA0 + 8'(i);
      tick();
      n_checks++;
      if (cpu_ack !== 1'b1 || fifo_level !== 5'(i + 1)) begin
        n_fail++; $display("FAIL fifo_push %0d: got ack=%b level=%0d, expected ack=1 level=%0d", i, cpu_ack, fifo_level, i + 1);
      end
      cpu_req = 1'b0;
      tick();
      n_checks++;
      if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL fifo_ack_pulse %0d: got %b, expected 0", i, cpu_ack); end
    end
    cpu_req = 1'b1; cpu_addr = 16'h2004; cpu_wdata = 8'hA4;
    repeat (3) begin
      tick();
      n_checks++;
      if (cpu_ack !== 1'b0 || fifo_level !== 5'd4 || mem_we !== 1'b0) begin
        n_fail++; $display("FAIL fifo_full_stall: got ack=%b level=%0d we=%b, expected ack=0 level=4 we=0", cpu_ack, fifo_level, mem_we);
      end
    end
    render_req = 1'b0;
    k = 0; got = 1'b0;
    while (!got && k < 10) begin tick(); k++; if (cpu_ack === 1'b1) got = 1'b1; end
    n_checks++;
    if (!got || k != 3 || fifo_level !== 5'd4) begin
      n_fail++; $display("FAIL fifo_stalled_ack: got ack=%b after %0d cycles level=%0d, expected ack after 3 level=4", got, k, fifo_level);
    end
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_addr = 16'h2005; cpu_wdata = 8'hA5;
    k = 0; got = 1'b0;
    while (!got && k < 10) begin tick(); k++; if (cpu_ack === 1'b1) got = 1'b1; end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL fifo_last_ack: got no ack in %0d cycles, expected ack", k); end
    cpu_req = 1'b0;
    k = 0;
    while ((fifo_level !== 5'd0 || log_addr.size() < base + 6) && k < 50) begin tick(); k++; end
    tick();
    n_checks++;
    if (log_addr.size() != base + 6 || fifo_level !== 5'd0) begin
      n_fail++; $display("FAIL fifo_drain_count: got %0d writes level=%0d, expected 6 writes level=0", log_addr.size() - base, fifo_level);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (log_addr[base + i] !== 16'h2000 + 16'(i) || log_data[base + i] !== 8'hA0 + 8'(i)) begin
          n_fail++;
          $display("FAIL fifo_order %0d: got %h/%h, expected %h/%h", i, log_addr[base + i], log_data[base + i],
                   16'h2000 + 16'(i), 8'hA0 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_read_after_writes();
    int base;
    int k;
    bit got;
    preload(14'h23C0, 8'h5A);
    base = log_addr.size();
    render_req = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300 + 16'(i); cpu_wdata = 8'h11 * 8'(i + 1);
      tick();
      cpu_req = 1'b0;
      tick();
    end
    n_checks++;
    if (fifo_level !== 5'd2) begin n_fail++; $display("FAIL raw_queued: got level=%0d, expected 2", fifo_level); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h23C0;
    render_req = 1'b0;
    k = 0; got = 1'b0;
    while (!got && k < 20) begin tick(); k++; if (cpu_ack === 1'b1) got = 1'b1; end
    cpu_req = 1'b0;
    n_checks++;
    if (!got || k != 8 || cpu_rdata !== 8'h5A) begin
      n_fail++; $display("FAIL raw_read: got ack=%b after %0d cycles rdata=%h, expected ack after 8 rdata=5a", got, k, cpu_rdata);
    end
    n_checks++;
    if (log_addr.size() != base + 2) begin
      n_fail++; $display("FAIL raw_writes_first: got %0d writes before ack, expected 2", log_addr.size() - base);
    end else if (log_addr[base] !== 16'h0300 || log_data[base] !== 8'h11 ||
                 log_addr[base + 1] !== 16'h0301 || log_data[base + 1] !== 8'h22) begin
      n_fail++; $display("FAIL raw_writes_first: got %h/%h %h/%h, expected 0300/11 0301/22",
                         log_addr[base], log_data[base], log_addr[base + 1], log_data[base + 1]);
    end
    tick();
  endtask

  task automatic test_reset_aborts();
    int base;
    render_req = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0400 + 16'(i); cpu_wdata = 8'hC0;
      tick();
      cpu_req = 1'b0;
      tick();
    end
    base = log_addr.size();
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (fifo_level !== 5'd0 || render_grant !== 1'b0) begin
      n_fail++; $display("FAIL abort_async: got level=%0d grant=%b, expected level=0 grant=0", fifo_level, render_grant);
    end
    render_req = 1'b0;
    tick();
    reset = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (log_addr.size() != base || cpu_ack !== 1'b0 || fifo_level !== 5'd0) begin
      n_fail++; $display("FAIL abort_lost: got %0d writes ack=%b level=%0d, expected 0 writes ack=0 level=0",
                         log_addr.size() - base, cpu_ack, fifo_level);
    end
  endtask
`else
  task automatic test_direct_write();
    render_req = 1'b1;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'hA0;
    repeat (5) begin
      tick();
      n_checks++;
      if (cpu_ack !== 1'b0 || mem_we !== 1'b0 || fifo_level !== 5'd0) begin
        n_fail++; $display("FAIL dw_stall: got ack=%b we=%b level=%0d, expected ack=0 we=0 level=0", cpu_ack, mem_we, fifo_level);
      end
    end
    render_req = 1'b0;
    tick();  // M: back to IDLE
    n_checks++;
    if (render_grant !== 1'b0 || cpu_ack !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL dw_idle_slot: got grant=%b ack=%b we=%b, expected 0 0 0", render_grant, cpu_ack, mem_we);
    end
    tick();  // M+1: write issued and acked together
    n_checks++;
    if (mem_we !== 1'b1 || cpu_ack !== 1'b1 || mem_addr !== 16'h2000 || mem_wdata !== 8'hA0 || fifo_level !== 5'd0) begin
      n_fail++;
      $display("FAIL dw_write: got we=%b ack=%b addr=%h data=%h level=%0d, expected we=1 ack=1 addr=2000 data=a0 level=0",
               mem_we, cpu_ack, mem_addr, mem_wdata, fifo_level);
    end
    tick();  // request still high during the ack cycle
    n_checks++;
    if (cpu_ack !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL dw_single: got ack=%b we=%b, expected 0 0", cpu_ack, mem_we);
    end
    cpu_req = 1'b0;
    tick();
    n_checks++;
    if (vram[14'h2000] !== 8'hA0 || cpu_ack !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL dw_mem: got vram=%h ack=%b we=%b, expected a0 0 0", vram[14'h2000], cpu_ack, mem_we);
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hC005; cpu_wdata = 8'h77;
    tick();
    n_checks++;
    if (mem_we !== 1'b1 || cpu_ack !== 1'b1 || mem_addr !== 16'h0005 || mem_wdata !== 8'h77) begin
      n_fail++; $display("FAIL dw_idle_write: got we=%b ack=%b addr=%h data=%h, expected we=1 ack=1 addr=0005 data=77",
                         mem_we, cpu_ack, mem_addr, mem_wdata);
    end
    cpu_req = 1'b0;
    tick();
    n_checks++;
    if (mem_we !== 1'b0 || cpu_ack !== 1'b0) begin
      n_fail++; $display("FAIL dw_idle_end: got we=%b ack=%b, expected 0 0", mem_we, cpu_ack);
    end
  endtask
`endif

  task automatic test_invariants();
    n_checks++;
    if (bad_we_grant != 0) begin n_fail++; $display("FAIL inv_we_grant: got %0d cycles, expected 0", bad_we_grant); end
    n_checks++;
    if (bad_addr_hi != 0) begin n_fail++; $display("FAIL inv_addr_hi: got %0d cycles, expected 0", bad_addr_hi); end
    n_checks++;
    if (bad_ack_run != 0) begin n_fail++; $display("FAIL inv_ack_run: got %0d cycles, expected 0", bad_ack_run); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_render();
    test_reset_mid_render();
    test_cpu_read();
    test_read_then_render();
`ifdef PPU_ARB_WRITE_FIFO_EN
    test_fifo_render();
    test_read_after_writes();
    test_reset_aborts();
`else
    test_direct_write();
`endif
    tick();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
